sr_ignition_trigger: RTL

Drives the trigger side of `sr_ignition_controller`: it produces the `coherence_in` and `beta_quiet` inputs the controller arms on. Raw PLV and beta-band amplitude are smoothed with first-order EMAs. Beta-quiet is qualified with hysteresis and a dwell timer. While the controller reports an active ignition, the block holds the quiet flag low, and it counts completed ignition onsets. It runs on the same 4 kHz `clk_en` as the controller.

---
 rtl/sr_ignition_trigger.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sr_ignition_trigger.sv
// Trigger front end for sr_ignition_controller: EMA-smoothed PLV and beta amplitude,
// hysteretic beta-quiet qualification with dwell, ignition lockout and onset counting.
module sr_ignition_trigger #(
    parameter int WIDTH       = 18,
    parameter int FRAC        = 14,
    parameter int ALPHA_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] plv_raw,
    input  logic signed [WIDTH-1:0] beta_amp,
    input  logic                    ignition_active,
    input  logic signed [WIDTH-1:0] beta_lo_thr,
    input  logic signed [WIDTH-1:0] beta_hi_thr,
    input  logic signed [WIDTH-1:0] coh_thr,
    input  logic [15:0]             quiet_dwell,
    output logic signed [WIDTH-1:0] coherence_out,
    output logic                    beta_quiet,
    output logic                    trigger_ready,
    output logic [1:0]              trig_state,
    output logic [7:0]              event_count
);

    localparam logic signed [WIDTH-1:0] UNITY = WIDTH'(2 ** FRAC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        QUIET   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    function automatic logic signed [WIDTH-1:0] clamp_unit(input logic signed [WIDTH-1:0] x);
        if (x < 0)
            return '0;
        else if (x > UNITY)
            return UNITY;
        else
            return x;
    endfunction

    // Difference kept one bit wider so the subtraction cannot wrap; floor shift.
    function automatic logic signed [WIDTH-1:0] ema_step(input logic signed [WIDTH-1:0] ema,
                                                         input logic signed [WIDTH-1:0] x);
        logic signed [WIDTH:0] diff;
        logic signed [WIDTH:0] sum;
        diff = {x[WIDTH-1], x} - {ema[WIDTH-1], ema};
        sum  = {ema[WIDTH-1], ema} + (diff >>> ALPHA_SHIFT);
        return WIDTH'(sum);
    endfunction

    logic signed [WIDTH-1:0] sample [2];
    logic signed [WIDTH-1:0] ema_cur [2];
    logic signed [WIDTH-1:0] ema_upd [2];

    assign sample[0] = plv_raw;
    assign sample[1] = beta_amp;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ema
        logic signed [WIDTH-1:0] ema_reg;
        logic signed [WIDTH-1:0] ema_next;

        assign ema_next    = ema_step(ema_reg, clamp_unit(sample[gi]));
        assign ema_cur[gi] = ema_reg;
        assign ema_upd[gi] = ema_next;

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                ema_reg <= '0;
            else if (clk_en)
                ema_reg <= ema_next;
        end
    end

    state_t      state_reg, state_next;
    logic [15:0] dwell_reg, dwell_next;
    logic [16:0] dwell_inc;
    logic [16:0] dwell_min;
    logic        beta_quiet_reg;
    logic        trigger_ready_reg;
    logic        ignition_prev_reg;
    logic [7:0]  event_count_reg;

    assign dwell_inc = {1'b0, dwell_reg} + 17'd1;
    assign dwell_min = (quiet_dwell == 16'd0) ? 17'd1 : {1'b0, quiet_dwell};

    // Thresholds compare against the beta EMA held before this tick's update.
    always_comb begin
        state_next = state_reg;
        dwell_next = dwell_reg;
        if (ignition_active) begin
            state_next = LOCKOUT;
            dwell_next = '0;
        end else begin
            unique case (state_reg)
                LOCKOUT: state_next = IDLE;
                IDLE: begin
                    if (ema_cur[1] < beta_lo_thr) begin
                        state_next = QUALIFY;
                        dwell_next = '0;
                    end
                end
                QUALIFY: begin
                    if (ema_cur[1] > beta_hi_thr) begin
                        state_next = IDLE;
                    end else begin
                        dwell_next = dwell_inc[15:0];
                        if (dwell_inc >= dwell_min)
                            state_next = QUIET;
                    end
                end
                QUIET: begin
                    if (ema_cur[1] > beta_hi_thr)
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            dwell_reg         <= '0;
            beta_quiet_reg    <= 1'b0;
            trigger_ready_reg <= 1'b0;
            ignition_prev_reg <= 1'b0;
            event_count_reg   <= '0;
        end else if (clk_en) begin
            state_reg         <= state_next;
            dwell_reg         <= dwell_next;
            beta_quiet_reg    <= (state_next == QUIET);
            trigger_ready_reg <= (state_next == QUIET) && (ema_upd[0] >= coh_thr);
            ignition_prev_reg <= ignition_active;
            if (ignition_active && !ignition_prev_reg && (event_count_reg != 8'hFF))
                event_count_reg <= event_count_reg + 8'd1;
        end
    end

    assign coherence_out = ema_cur[0];
    assign beta_quiet    = beta_quiet_reg;
    assign trigger_ready = trigger_ready_reg;
    assign trig_state    = state_reg;
    assign event_count   = event_count_reg;

endmodule
